id_ex_stage: RTL and testbench

- ID/EX pipeline boundary of the 5-stage RV32I core.
- Registers decoded control and operand data from ID into EX.
- Detects load-use hazards, inserts bubbles, and freezes on EX hold.
- Drives the stall that holds the PC and IF/ID register; applies EX-resolved flushes (taken branch/jal/jalr).

---
 rtl/id_ex_stage_pkg.sv | 27 ++
 rtl/id_ex_stage_hazard_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 tb/tb_id_ex_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared control encodings used by the ID/EX boundary. These values mirror the core-wide ctrl_encode_def set.
// Also holds the grouped decoded-control type and the bubble value for that group.
package id_ex_stage_pkg;

  localparam logic [2:0] NPC_PLUS4 = 3'b000;
  localparam logic [4:0] ALUOp_nop = 5'b00000;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       alusrc;
    logic       ltype;
    logic [4:0] aluop;
    logic [2:0] npcop;
    logic [1:0] wdsel;
    logic [2:0] dm_ctrl;
  } ctrl_t;

  function automatic ctrl_t bubble_ctrl();
    ctrl_t c;
    c       = '0;
    c.aluop = ALUOp_nop;
    c.npcop = NPC_PLUS4;
    return c;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detector: a load sitting in EX whose destination a valid ID instruction reads.
// Loads that target x0 never count as a hazard.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_ltype,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  output logic              lu
);

  logic w_load_in_ex;
  logic w_src_match;

  assign w_load_in_ex = ex_valid & ex_ltype & (ex_rd != '0);
  assign w_src_match  = (id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd));
  assign lu           = w_load_in_ex & id_valid & w_src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX hold freeze and EX-resolved flush.
// Optional event counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_regwrite,
  input  logic              id_memwrite,
  input  logic              id_alusrc,
  input  logic              id_ltype,
  input  logic [4:0]        id_aluop,
  input  logic [2:0]        id_npcop,
  input  logic [1:0]        id_wdsel,
  input  logic [2:0]        id_dm_ctrl,
  input  logic              ex_flush,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memwrite,
  output logic              ex_alusrc,
  output logic              ex_ltype,
  output logic [4:0]        ex_aluop,
  output logic [2:0]        ex_npcop,
  output logic [1:0]        ex_wdsel,
  output logic [2:0]        ex_dm_ctrl,
  output logic              stall_if,
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_flushes
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rd1;
  logic [XLEN-1:0]   r_rd2;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  ctrl_t             r_ctrl;

  ctrl_t             w_id_ctrl;
  logic              w_lu;
  logic              w_bubble;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid   (r_valid),
    .ex_ltype   (r_ctrl.ltype),
    .ex_rd      (r_rd),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .lu         (w_lu)
  );

  assign w_id_ctrl = '{regwrite: id_regwrite, memwrite: id_memwrite, alusrc: id_alusrc,
                       ltype: id_ltype, aluop: id_aluop, npcop: id_npcop,
                       wdsel: id_wdsel, dm_ctrl: id_dm_ctrl};

  // Hold freezes everything; otherwise a flush, a load-use or an empty ID slot all load a bubble.
  assign w_bubble = ~ex_hold & (ex_flush | w_lu | ~id_valid);

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_ctrl  <= bubble_ctrl();
    end else if (!ex_hold) begin
      r_valid <= id_valid;
      r_pc    <= id_pc;
      r_rd1   <= id_rd1;
      r_rd2   <= id_rd2;
      r_imm   <= id_imm;
      r_rs1   <= id_rs1;
      r_rs2   <= id_rs2;
      r_rd    <= id_rd;
      r_ctrl  <= w_id_ctrl;
    end
  end

  // A flush discards the ID instruction upstream, so it never needs to be held.
  assign stall_if = ~rst & (ex_hold | (w_lu & ~ex_flush));

  assign ex_valid    = r_valid;
  assign ex_pc       = r_pc;
  assign ex_rd1      = r_rd1;
  assign ex_rd2      = r_rd2;
  assign ex_imm      = r_imm;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;
  assign ex_regwrite = r_ctrl.regwrite;
  assign ex_memwrite = r_ctrl.memwrite;
  assign ex_alusrc   = r_ctrl.alusrc;
  assign ex_ltype    = r_ctrl.ltype;
  assign ex_aluop    = r_ctrl.aluop;
  assign ex_npcop    = r_ctrl.npcop;
  assign ex_wdsel    = r_ctrl.wdsel;
  assign ex_dm_ctrl  = r_ctrl.dm_ctrl;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_perf_bubbles;
  logic [31:0] r_perf_flushes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_bubbles <= '0;
      r_perf_flushes <= '0;
    end else if (!ex_hold) begin
      if (ex_flush)  r_perf_flushes <= r_perf_flushes + 32'd1;
      else if (w_lu) r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_bubbles = r_perf_bubbles;
  assign perf_flushes = r_perf_flushes;
`else
  assign perf_bubbles = '0;
  assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed table, multi-cycle corner sequences, then random traffic
// checked against a behavioural model of the EX register contents and event counts.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        regwrite;
    logic        memwrite;
    logic        alusrc;
    logic        ltype;
    logic [4:0]  aluop;
    logic [2:0]  npcop;
    logic [1:0]  wdsel;
    logic [2:0]  dm_ctrl;
  } ex_t;

  typedef struct {
    bit       rst, hold, flush, vld;
    bit [4:0] rs1, rs2, rd;
    bit       u1, u2, ld, rw;
    bit       e_stall, e_valid;
    bit [4:0] e_rd;
    bit       e_rw;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_use_rs1, id_use_rs2;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_aluop;
  logic        id_regwrite, id_memwrite, id_alusrc, id_ltype;
  logic [2:0]  id_npcop, id_dm_ctrl;
  logic [1:0]  id_wdsel;
  logic        ex_flush, ex_hold;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_aluop;
  logic        ex_regwrite, ex_memwrite, ex_alusrc, ex_ltype;
  logic [2:0]  ex_npcop, ex_dm_ctrl;
  logic [1:0]  ex_wdsel;
  logic        stall_if;
  logic [31:0] perf_bubbles, perf_flushes;

  int          total = 0;
  int          bad   = 0;
  ex_t         m;
  logic [31:0] pb, pf;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_ltype(id_ltype),
    .id_aluop(id_aluop), .id_npcop(id_npcop), .id_wdsel(id_wdsel), .id_dm_ctrl(id_dm_ctrl),
    .ex_flush(ex_flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_ltype(ex_ltype),
    .ex_aluop(ex_aluop), .ex_npcop(ex_npcop), .ex_wdsel(ex_wdsel), .ex_dm_ctrl(ex_dm_ctrl),
    .stall_if(stall_if), .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
  );

  task automatic chk(string nm, logic [199:0] got, logic [199:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic ex_t dut_ex();
    ex_t d;
    d = '{valid: ex_valid, pc: ex_pc, rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd,
          rd1: ex_rd1, rd2: ex_rd2, imm: ex_imm, regwrite: ex_regwrite, memwrite: ex_memwrite,
          alusrc: ex_alusrc, ltype: ex_ltype, aluop: ex_aluop, npcop: ex_npcop,
          wdsel: ex_wdsel, dm_ctrl: ex_dm_ctrl};
    return d;
  endfunction

  function automatic ex_t id_view();
    ex_t d;
    d = '{valid: 1'b1, pc: id_pc, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
          rd1: id_rd1, rd2: id_rd2, imm: id_imm, regwrite: id_regwrite, memwrite: id_memwrite,
          alusrc: id_alusrc, ltype: id_ltype, aluop: id_aluop, npcop: id_npcop,
          wdsel: id_wdsel, dm_ctrl: id_dm_ctrl};
    return d;
  endfunction

  task automatic set_id(bit v, bit [4:0] s1, bit [4:0] s2, bit [4:0] d, bit u1, bit u2, bit ld, bit rw);
    id_valid = v;  id_rs1 = s1; id_rs2 = s2; id_rd = d;
    id_use_rs1 = u1; id_use_rs2 = u2; id_ltype = ld; id_regwrite = rw;
    id_pc = $urandom & 32'hffff_fffc; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_memwrite = 1'($urandom); id_alusrc = 1'($urandom); id_aluop = 5'($urandom);
    id_npcop = 3'($urandom); id_wdsel = 2'($urandom); id_dm_ctrl = 3'($urandom);
  endtask

  // One clock: check stall_if mid-cycle, advance the model by the stage rules, check EX after the edge.
  task automatic step(string nm);
    bit lu, e_stall;
    lu = m.valid && m.ltype && (m.rd != 0) && id_valid &&
         ((id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd));
    e_stall = !rst && (ex_hold || (lu && !ex_flush));
    @(negedge clk);
    chk({nm, ".stall"}, 200'(stall_if), 200'(e_stall));
    if (rst) begin
      m = '0; pb = 0; pf = 0;
    end else if (!ex_hold) begin
      if (ex_flush)      begin m = '0; pf = pf + 1; end
      else if (lu)       begin m = '0; pb = pb + 1; end
      else if (!id_valid) m = '0;
      else               m = id_view();
    end
    @(posedge clk); #1;
    chk({nm, ".ex"}, 200'(dut_ex()), 200'(m));
`ifdef ID_EX_PERF_CNT_EN
    chk({nm, ".perf_b"}, 200'(perf_bubbles), 200'(pb));
    chk({nm, ".perf_f"}, 200'(perf_flushes), 200'(pf));
`else
    chk({nm, ".perf"}, 200'({perf_bubbles, perf_flushes}), 200'(0));
`endif
  endtask

  vec_t tbl[13];
  ex_t  snap;

  initial begin
    m = '0; pb = 0; pf = 0;
    rst = 1'b1; ex_hold = 1'b0; ex_flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    //           rst hold fl vld rs1 rs2 rd u1 u2 ld rw | stall valid rd rw
    tbl[0]  = '{1, 0, 0, 1, 1, 0, 5, 1, 0, 1, 1,  0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 1, 0, 5, 1, 0, 1, 1,  0, 1, 5, 1};
    tbl[2]  = '{0, 0, 0, 1, 5, 2, 6, 1, 1, 0, 1,  1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 5, 2, 6, 1, 1, 0, 1,  0, 1, 6, 1};
    tbl[4]  = '{0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 1,  0, 1, 0, 1};
    tbl[5]  = '{0, 0, 0, 1, 0, 0, 7, 1, 1, 0, 1,  0, 1, 7, 1};
    tbl[6]  = '{0, 0, 0, 1, 1, 0, 9, 1, 0, 1, 1,  0, 1, 9, 1};
    tbl[7]  = '{0, 0, 1, 1, 9, 0, 10, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 1, 0, 3, 1, 0, 1, 1,  0, 1, 3, 1};
    tbl[9]  = '{0, 0, 0, 1, 3, 0, 4, 1, 0, 1, 1,  1, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 3, 0, 4, 1, 0, 1, 1,  0, 1, 4, 1};
    tbl[11] = '{0, 0, 0, 1, 1, 4, 8, 0, 1, 0, 1,  1, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 1, 1, 4, 8, 0, 1, 0, 1,  0, 1, 8, 1};

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; ex_hold = tbl[i].hold; ex_flush = tbl[i].flush;
      set_id(tbl[i].vld, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].u1, tbl[i].u2, tbl[i].ld, tbl[i].rw);
      #1;
      chk($sformatf("tbl%0d.stall", i), 200'(stall_if), 200'(tbl[i].e_stall));
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.out", i), 200'({ex_valid, ex_rd, ex_regwrite}),
          200'({tbl[i].e_valid, tbl[i].e_rd, tbl[i].e_rw}));
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("tbl.perf", 200'({perf_bubbles, perf_flushes}), 200'({32'd3, 32'd1}));
`endif

    // Hold for three cycles while ID keeps changing.
    ex_flush = 0; ex_hold = 0;
    set_id(1, 2, 0, 11, 1, 0, 0, 1);
    step("hold.load");
    snap = m;
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'(i), 5'(i + 1), 5'(20 + i), 1, 1, 1, 1);
      #1;
      chk($sformatf("hold%0d.stall", i), 200'(stall_if), 200'(1));
      step($sformatf("hold%0d", i));
      chk($sformatf("hold%0d.frozen", i), 200'(dut_ex()), 200'(snap));
    end
    ex_hold = 0;
    set_id(1, 3, 3, 12, 1, 1, 0, 1);
    step("hold.release");
    chk("hold.release.rd", 200'({ex_valid, ex_rd}), 200'({1'b1, 5'd12}));

    // Hold and flush together, then hold drops with flush still high.
    ex_hold = 1; ex_flush = 1;
    set_id(1, 4, 4, 13, 1, 1, 0, 1);
    step("hf.frozen");
    chk("hf.frozen.rd", 200'({ex_valid, ex_rd}), 200'({1'b1, 5'd12}));
    ex_hold = 0;
    step("hf.bubble");
    chk("hf.bubble.valid", 200'(ex_valid), 200'(0));

    // Reset asserted during a hold with a valid instruction in EX.
    ex_flush = 0;
    set_id(1, 1, 1, 14, 1, 1, 1, 1);
    step("rh.load");
    ex_hold = 1; rst = 1;
    #1;
    chk("rh.stall", 200'(stall_if), 200'(0));
    step("rh.reset");
    chk("rh.empty", 200'({dut_ex(), perf_bubbles, perf_flushes}), 200'(0));
    rst = 0; ex_hold = 0;

    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      ex_hold  = ($urandom_range(0, 99) < 12);
      ex_flush = ($urandom_range(0, 99) < 10);
      set_id($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             $urandom_range(0, 9) < 4, 1'($urandom));
      step($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
